// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Definitions shared by the systolic MAC array and its feeder.
//   state_t     : feeder FSM states
//   DEF_D_W     : default operand width shared with the array
//   DEF_N       : default array dimension shared with the array
//   stream_len  : number of skewed replay steps for an N x N job (3N-2)
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int DEF_D_W = 8;
    localparam int DEF_N   = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // The last operand pair k=N-1 reaches PE(N-1,N-1) at step (N-1)+(N-1)+(N-1).
    function automatic int stream_len(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_mux.sv
// ---------------------------------------------------------------------------
// skew_mux
// Picks the element of one array lane for replay step t. Lane `lane` runs
// `lane` steps behind lane 0, so it shows element (t - lane) while that index
// lies inside 0..N-1, and zero otherwise.
// Ports:
//   lane_data  in   N*D_W   the lane's N elements, element i at [i*D_W +: D_W]
//   t          in   CNT_W   replay step
//   lane       in   CNT_W   lane index (row for x, column for y)
//   elem       out  D_W     selected element or zero
// ---------------------------------------------------------------------------
module skew_mux #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int CNT_W = 3
) (
    input  logic [N*D_W-1:0] lane_data,
    input  logic [CNT_W-1:0] t,
    input  logic [CNT_W-1:0] lane,
    output logic [D_W-1:0]   elem
);

    logic [CNT_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it holding its old value (a latch).
    always_comb begin
        elem = '0;
        idx  = t - lane;
        // t >= lane guards the unsigned wrap of t - lane before the window starts.
        if (t >= lane && idx < CNT_W'(N)) begin
            elem = lane_data[idx*D_W +: D_W];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Upstream stage of the N x N systolic MAC array. Buffers one operand pair
// (A by rows, B by columns, one of each per load beat), replays them
// diagonally skewed onto the array inputs with an accumulator-clear pulse,
// and flags when the array outputs hold C = A*B.
//
// Optional build macro: FEEDER_JOB_CNT_EN adds a 16-bit wrapping count of
// finished jobs on job_cnt.
//
// Ports:
//   clk       in   1       clock
//   rst       in   1       synchronous reset, active low
//   in_valid  in   1       load beat valid
//   in_ready  out  1       beat accepted when in_valid && in_ready
//   in_a_row  in   N*D_W   row k of A, element j at [j*D_W +: D_W]
//   in_b_col  in   N*D_W   column k of B, element j (= B[j][k]) at [j*D_W +: D_W]
//   x_flat    out  N*D_W   array row inputs, row r at [(r+1)*D_W-1 -: D_W]
//   y_flat    out  N*D_W   array column inputs, column c at [(c+1)*D_W-1 -: D_W]
//   init      out  1       accumulator clear, high on the first replay step
//   busy      out  1       high whenever the FSM is not IDLE
//   done      out  1       one-cycle pulse, array z_flat holds the product
//   job_cnt   out  16      finished-job count (FEEDER_JOB_CNT_EN only)
// ---------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int D_W     = DEF_D_W,
    parameter int N       = DEF_N,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*D_W-1:0] in_a_row,
    input  logic [N*D_W-1:0] in_b_col,
    output logic [N*D_W-1:0] x_flat,
    output logic [N*D_W-1:0] y_flat,
    output logic             init,
    output logic             busy,
    output logic             done
`ifdef FEEDER_JOB_CNT_EN
    ,
    output logic [15:0]      job_cnt
`endif
);

    localparam int CNT_W  = $clog2(3 * N);
    localparam int IDX_W  = $clog2(N);
    localparam int LAST_T = stream_len(N) - 1;
    localparam int DR_W   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat, beat_nxt;
    logic [CNT_W-1:0] t, t_nxt;
    logic [DR_W-1:0]  drain, drain_nxt;
    logic             accept;

    // Operand buffers: a_buf[r] holds row r of A, b_buf[c] holds column c of B,
    // so each entry is exactly the element sequence one array lane consumes.
    logic [N*D_W-1:0] a_buf [N];
    logic [N*D_W-1:0] b_buf [N];
    logic [N*D_W-1:0] x_next, y_next;

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        t_nxt     = t;
        drain_nxt = drain;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                    beat_nxt  = CNT_W'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    if (beat == CNT_W'(N - 1)) begin
                        state_nxt = STREAM;
                        beat_nxt  = '0;
                        t_nxt     = '0;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (t == CNT_W'(LAST_T)) begin
                    t_nxt     = '0;
                    drain_nxt = '0;
                    state_nxt = (MAC_LAT == 0) ? DONE : DRAIN;
                end else begin
                    t_nxt = t + 1'b1;
                end
            end
            DRAIN: begin
                if (drain == DR_W'(MAC_LAT - 1)) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain + 1'b1;
                end
            end
            DONE: begin
                // A beat offered here is ignored: in_ready is low in DONE.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- skewed lanes
    // Lanes are evaluated for the step being entered, so the registered
    // outputs carry step t's values during step t.
    for (genvar r = 0; r < N; r++) begin : g_x_lane
        skew_mux #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) u_x_mux (
            .lane_data (a_buf[r]),
            .t         (t_nxt),
            .lane      (CNT_W'(r)),
            .elem      (x_next[r*D_W +: D_W])
        );
    end

    for (genvar c = 0; c < N; c++) begin : g_y_lane
        skew_mux #(.D_W(D_W), .N(N), .CNT_W(CNT_W)) u_y_mux (
            .lane_data (b_buf[c]),
            .t         (t_nxt),
            .lane      (CNT_W'(c)),
            .elem      (y_next[c*D_W +: D_W])
        );
    end

    // ------------------------------------------------------ state and outputs
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            beat   <= '0;
            t      <= '0;
            drain  <= '0;
            x_flat <= '0;
            y_flat <= '0;
            init   <= 1'b0;
        end else begin
            state  <= state_nxt;
            beat   <= beat_nxt;
            t      <= t_nxt;
            drain  <= drain_nxt;
            x_flat <= (state_nxt == STREAM) ? x_next : '0;
            y_flat <= (state_nxt == STREAM) ? y_next : '0;
            // Entering STREAM is the step-0 edge: clear the accumulators once.
            init   <= (state == LOAD) && (state_nxt == STREAM);
        end
    end

    // Step 0 only needs element 0 of lane 0, which was stored by beat 0, so
    // the last beat can be written on the same edge that starts the replay.
    // NOTE: the operand buffers carry no reset; their contents are only read
    // after a full load has overwritten every entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[beat[IDX_W-1:0]] <= in_a_row;
            b_buf[beat[IDX_W-1:0]] <= in_b_col;
        end
    end

`ifdef FEEDER_JOB_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            job_cnt <= '0;
        end else if (state == DONE) begin
            job_cnt <= job_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the N×N systolic MAC array.
- Accepts one N×N operand pair A and B through a valid/ready load port, one row of A and one column of B per beat, and buffers both.
- Replays the operands diagonally skewed onto the array's x_flat/y_flat inputs, with the init pulse that clears the MAC accumulators.
- Signals when the array's z_flat outputs hold the finished product.

Parameters:
- D_W, 8: operand width, matching the array's D_W.
- N, 2: array dimension; legal values are 2 or greater.
- MAC_LAT, 1: cycles from the last skewed operand to a settled z_flat.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- in_valid  input  1  load beat valid
- in_ready  output  1  load beat accepted when in_valid && in_ready
- in_a_row  input  N*D_W  row k of A; element j at [j*D_W +: D_W]
- in_b_col  input  N*D_W  column k of B; element j (= B[j][k]) at [j*D_W +: D_W]
- x_flat  output  N*D_W  to array; row r at [(r+1)*D_W-1 -: D_W]
- y_flat  output  N*D_W  to array; column c at [(c+1)*D_W-1 -: D_W]
- init  output  1  to array init; one-cycle pulse
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse; z_flat holds C = A·B

Behaviour:
- Reset, sampled when rst==0 at a clk edge: state=IDLE, beat/step counters=0, in_ready=1, x_flat=0, y_flat=0, init=0, busy=0, done=0. Buffer contents are don't-care.
- Reset mid-operation aborts immediately. No done is produced, and outputs return to reset values on the next edge.
- IDLE: in_ready=1. An accepted beat stores k=0 and moves to LOAD with beat=1.
- LOAD: in_ready=1. Each accepted beat stores row/column k=beat and increments beat.
  - Acceptance of beat N-1 moves to STREAM with t=0.
  - Cycles with in_valid=0 are stalls, with no timeout.
- STREAM, lasting 3N-2 cycles, t = 0..3N-3: in_ready=0.
  - Registered outputs during step t: x[r] = A[r][t-r] if 0 ≤ t-r < N, else 0.
  - Registered outputs during step t: y[c] = B[t-c][c] if 0 ≤ t-c < N, else 0.
  - init=1 only during t=0. Outputs are registered so that t=0 values appear the cycle after the last LOAD beat.
- DRAIN, MAC_LAT cycles: x_flat=0, y_flat=0, in_ready=0.
- DONE, one cycle: done=1, then return to IDLE with in_ready=1.
  - A beat offered in that same cycle is not accepted.
- Latency: from the last load-beat acceptance to done is 3N-2+MAC_LAT+1 cycles.
- Widths: counters are clog2(3N) bits; no arithmetic on data; operands pass through unmodified.

Optional Feature:
- FEEDER_JOB_CNT_EN defined: adds output job_cnt [15:0].
  - Reset value 0; increments on each done pulse.
  - Wraps from 16'hFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package systolic_pkg holds:
  - FSM state typedef: IDLE, LOAD, STREAM, DRAIN, DONE.
  - Default D_W/N constants shared with the array.
  - Constant function for stream length, 3N-2.
- One natural sub-module, skew_mux:
  - Combinational select of one lane's element from the buffer for a given t and lane index.
  - Zero outside the valid window.
  - Instantiated once per row lane and once per column lane.

Test Plan:
- Basic, N=2: load A=[[1,2],[3,4]], B=[[5,6],[7,8]] →
  - t0: x=(1,0), y=(5,0), init=1.
  - t1: x=(2,3), y=(7,6).
  - t2: x=(0,4), y=(0,8).
  - done 1+MAC_LAT cycles after t2; array z = [[19,22],[43,50]].
- Load stalls: same data with in_valid dropped for 3 cycles between beats → identical skewed sequence; in_ready stays 1 during the stalls.
- Backpressure: in_valid held high through STREAM/DRAIN/DONE → in_ready=0, no extra beats captured; next job begins only from IDLE.
- Mid-stream reset: rst=0 at t=1 → next cycle all outputs 0, busy=0, no done. A fresh load afterwards yields the correct result.
- Back-to-back jobs, N=4: identity A, B=(i*4+j) → two consecutive jobs, each done with z equal to B; init pulses exactly once per job.
- With FEEDER_JOB_CNT_EN: three jobs → job_cnt=3; preload near wrap via forced counter → 16'hFFFF then 0 after done.
